// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl
// Memory/IO access controller between the LC-3 datapath bus and the RAM block.
// Owns MAR/MDR, sequences each access with WAIT_STATES extra cycles, and pulses
// R for one cycle when the access completes. Addresses at or above IO_BASE are
// served by the internal I/O registers (KBSR, KBDR, DSR, DDR, MCR) and never
// enable the RAM.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   BUS                   datapath bus (source for MAR/MDR loads)
//   LD_MAR, LD_MDR        register loads, honoured only while MIO_EN=0
//   MIO_EN, R_W           access request and type (1=write, 0=read)
//   MDR, R                memory data register, one-cycle completion pulse
//   ADDR, DATAin          RAM address (=MAR) and write data (=MDR)
//   MEM_R_W, MEM_EN       RAM write strobe and enable
//   MEMout                RAM combinational read data
//   KB_DATA, KB_STROBE    keyboard character and its valid pulse
//   DISP_DATA, DISP_STROBE, DISP_ACK  display character handshake
//   RUN                   MCR[15], machine clock enable
module lc3_mem_ctrl #(
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] IO_BASE     = 16'hFE00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] BUS,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        R_W,
  output logic [15:0] MDR,
  output logic        R,
  output logic [15:0] ADDR,
  output logic [15:0] DATAin,
  output logic        MEM_R_W,
  output logic        MEM_EN,
  input  logic [15:0] MEMout,
  input  logic [7:0]  KB_DATA,
  input  logic        KB_STROBE,
  output logic [7:0]  DISP_DATA,
  output logic        DISP_STROBE,
  input  logic        DISP_ACK,
  output logic        RUN
);

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        r_q;
  logic        mem_en_q;
  logic        mem_r_w_q;
  logic        kbsr_flag;
  logic [7:0]  kbdr;
  logic        dsr_flag;
  logic [7:0]  disp_data_q;
  logic        disp_strobe_q;
  logic        run_q;
  logic        is_io;
  logic [15:0] io_rdata;

  assign is_io = (mar >= IO_BASE);

  always_comb begin
    io_rdata = 16'h0000;
    case (mar)
      KBSR_ADDR: io_rdata = {kbsr_flag, 15'b0};
      KBDR_ADDR: io_rdata = {8'b0, kbdr};
      DSR_ADDR:  io_rdata = {dsr_flag, 15'b0};
      MCR_ADDR:  io_rdata = {run_q, 15'b0};
      default:   io_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      wr            <= 1'b0;
      mar           <= '0;
      mdr           <= '0;
      r_q           <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_r_w_q     <= 1'b0;
      kbsr_flag     <= 1'b0;
      kbdr          <= '0;
      dsr_flag      <= 1'b1;
      disp_data_q   <= '0;
      disp_strobe_q <= 1'b0;
      run_q         <= 1'b1;
    end else begin
      r_q           <= 1'b0;
      mem_r_w_q     <= 1'b0;
      disp_strobe_q <= 1'b0;

      // MAR/MDR are frozen for the whole access.
      if (!MIO_EN) begin
        if (LD_MAR) mar <= BUS;
        if (LD_MDR) mdr <= BUS;
      end

      // Display ack is assigned before the FSM so a coincident DDR write wins.
      if (DISP_ACK) dsr_flag <= 1'b1;

      case (state)
        S_IDLE: begin
          if (MIO_EN) begin
            state    <= S_WAIT;
            cnt      <= 4'(WAIT_STATES);
            wr       <= R_W;
            mem_en_q <= ~is_io;
          end
        end
        S_WAIT: begin
          if (!MIO_EN) begin
            state    <= S_IDLE;
            mem_en_q <= 1'b0;
          end else if (cnt == 4'd0) begin
            state     <= S_DONE;
            r_q       <= 1'b1;
            mem_r_w_q <= wr & ~is_io;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          state    <= S_HOLD;
          mem_en_q <= 1'b0;
          if (!wr) begin
            mdr <= is_io ? io_rdata : MEMout;
            if (mar == KBDR_ADDR) kbsr_flag <= 1'b0;
          end else if (mar == DDR_ADDR) begin
            disp_data_q   <= mdr[7:0];
            dsr_flag      <= 1'b0;
            disp_strobe_q <= 1'b1;
          end else if (mar == MCR_ADDR) begin
            run_q <= mdr[15];
          end
        end
        S_HOLD: begin
          if (!MIO_EN) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A new character beats a coincident KBDR-read clear.
      if (KB_STROBE) begin
        kbdr      <= KB_DATA;
        kbsr_flag <= 1'b1;
      end
    end
  end

  // Reset kills the RAM strobes and R in the very cycle it is asserted.
  assign R           = r_q & ~reset;
  assign MEM_EN      = mem_en_q & ~reset;
  assign MEM_R_W     = mem_r_w_q & ~reset;
  assign MDR         = mdr;
  assign ADDR        = mar;
  assign DATAin      = mdr;
  assign DISP_DATA   = disp_data_q;
  assign DISP_STROBE = disp_strobe_q;
  assign RUN         = run_q;

endmodule
